// File: rtl/cond_unit_pkg.sv
// cond_pkg: condition encodings and flag/flag-write bit positions shared by the condition unit.
package cond_pkg;
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;
endpackage

// File: rtl/cond_unit_if.sv
// cond_unit_if: decoder-side request and writeback-side gated controls with valid/ready handshakes.
interface cond_unit_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       out_valid;
  logic       out_ready;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       CondEx;
  logic       cond_err;
  modport master (
    output in_valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, out_ready,
    input  in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx, cond_err
  );
  modport slave (
    input  in_valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, out_ready,
    output in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx, cond_err
  );
endinterface

// File: rtl/cond_unit_check.sv
// cond_check: evaluates an ARM condition field against the stored {N,Z,C,V} flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx,
  output logic       cond_err
);
  logic n, z, c, v;
  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];
  always_comb begin
    CondEx = 1'b0;
    cond_err = (Cond == COND_NV);
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: flag register, condition gating of PC/reg/mem writes behind a 1-entry
// output register, and a saturating count of condition-failed instructions.
module cond_unit
  import cond_pkg::*;
#(
  parameter int         CNT_W    = 8,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             reset_n,
  cond_unit_if.slave       bus,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] skip_count
);
  logic cond_ex, err, accept;
  cond_check u_check (
    .Cond    (bus.Cond),
    .Flags   (Flags),
    .CondEx  (cond_ex),
    .cond_err(err)
  );
  assign bus.in_ready = ~bus.out_valid | bus.out_ready;
  assign accept = bus.in_valid & bus.in_ready;
  // Flags are committed at accept so a back-to-back successor already sees them.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      Flags <= FLAG_RST;
      bus.out_valid <= 1'b0;
      bus.PCSrc <= 1'b0;
      bus.RegWrite <= 1'b0;
      bus.MemWrite <= 1'b0;
      bus.CondEx <= 1'b0;
      bus.cond_err <= 1'b0;
      skip_count <= '0;
    end else if (accept) begin
      if (cond_ex & bus.FlagW[FLAGW_NZ]) Flags[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
      if (cond_ex & bus.FlagW[FLAGW_CV]) Flags[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
      bus.out_valid <= 1'b1;
      bus.PCSrc <= bus.PCS & cond_ex;
      bus.RegWrite <= bus.RegW & cond_ex & ~bus.NoWrite;
      bus.MemWrite <= bus.MemW & cond_ex;
      bus.CondEx <= cond_ex;
      bus.cond_err <= err;
      if (!cond_ex && skip_count != '1) skip_count <= skip_count + CNT_W'(1);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed vectors on a CNT_W=2 unit, with a default-width shadow unit on the same stimulus.
module tb_cond_unit;
  logic clk = 1'b0;
  logic reset_n;
  int vectors = 0;
  int miscompares = 0;
  int cnt = 0;
  logic [3:0] flags2, flags8;
  logic [1:0] skip2;
  logic [7:0] skip8;
  cond_unit_if a ();
  cond_unit_if b ();
  cond_unit #(.CNT_W(2), .FLAG_RST(4'b0101)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(a), .Flags(flags2), .skip_count(skip2)
  );
  cond_unit u8 (
    .clk(clk), .reset_n(reset_n), .bus(b), .Flags(flags8), .skip_count(skip8)
  );
  assign b.in_valid = a.in_valid;
  assign b.Cond = a.Cond;
  assign b.ALUFlags = a.ALUFlags;
  assign b.FlagW = a.FlagW;
  assign b.PCS = a.PCS;
  assign b.RegW = a.RegW;
  assign b.MemW = a.MemW;
  assign b.NoWrite = a.NoWrite;
  assign b.out_ready = a.out_ready;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                       input logic pcs, input logic regw, input logic memw, input logic nw);
    a.in_valid = vld;
    a.Cond = c;
    a.FlagW = fw;
    a.ALUFlags = alu;
    a.PCS = pcs;
    a.RegW = regw;
    a.MemW = memw;
    a.NoWrite = nw;
  endtask

  function automatic logic [1:0] sat2(input int n);
    return (n > 3) ? 2'd3 : n[1:0];
  endfunction

  task automatic issue(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu, input logic pcs,
                       input logic regw, input logic memw, input logic nw, input logic ex);
    drive(1'b1, c, fw, alu, pcs, regw, memw, nw);
    tick;
    if (!ex) cnt++;
    chk("condex", a.CondEx, ex);
    chk("out_valid", a.out_valid, 1'b1);
    chk("skip_count", skip2, sat2(cnt));
  endtask

  // e[i] is the expected CondEx of condition i with the flags set to f
  task automatic sweep(input logic [3:0] f, input logic [15:0] e);
    issue(4'hE, 2'b11, f, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flags_set", flags2, f);
    for (int i = 0; i < 16; i++) begin
      issue(i[3:0], 2'b00, ~f, 1'b1, 1'b1, 1'b1, 1'b0, e[i]);
      chk("sweep_pcsrc", a.PCSrc, e[i]);
      chk("sweep_regwrite", a.RegWrite, e[i]);
      chk("sweep_memwrite", a.MemWrite, e[i]);
      chk("sweep_cond_err", a.cond_err, i == 15);
      chk("sweep_flags", flags2, f);
    end
  endtask

  initial begin
    drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    a.out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) tick;
    chk("rst_out_valid", a.out_valid, 1'b0);
    chk("rst_flags", flags2, 4'b0101);
    chk("rst_flags8", flags8, 4'b0000);
    chk("rst_skip", skip2, 2'd0);
    chk("rst_condex", a.CondEx, 1'b0);
    chk("rst_regwrite", a.RegWrite, 1'b0);
    chk("rst_cond_err", a.cond_err, 1'b0);
    chk("rst_in_ready", a.in_ready, 1'b1);
    reset_n = 1'b1;
    tick;
    issue(4'hE, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t1_regwrite", a.RegWrite, 1'b1);
    chk("t1_flags", flags2, 4'b0100);
    chk("t1_pcsrc", a.PCSrc, 1'b0);
    issue(4'h0, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_pcsrc", a.PCSrc, 1'b1);
    issue(4'h1, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_memwrite", a.MemWrite, 1'b0);
    chk("t2_flags", flags2, 4'b0100);
    issue(4'hE, 2'b11, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t3_cmp_regwrite", a.RegWrite, 1'b0);
    chk("t3_flags", flags2, 4'b1000);
    issue(4'hB, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3_lt_regwrite", a.RegWrite, 1'b1);
    a.out_ready = 1'b0;
    drive(1'b1, 4'hE, 2'b11, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("t4_in_ready", a.in_ready, 1'b0);
    repeat (3) begin
      tick;
      chk("t4_stall_in_ready", a.in_ready, 1'b0);
      chk("t4_stall_valid", a.out_valid, 1'b1);
      chk("t4_stall_regwrite", a.RegWrite, 1'b1);
      chk("t4_stall_condex", a.CondEx, 1'b1);
      chk("t4_stall_flags", flags2, 4'b1000);
    end
    a.out_ready = 1'b1;
    #1;
    chk("t4_release_in_ready", a.in_ready, 1'b1);
    tick;
    chk("t4_accept_flags", flags2, 4'b0001);
    chk("t4_accept_valid", a.out_valid, 1'b1);
    chk("t4_accept_regwrite", a.RegWrite, 1'b1);
    issue(4'hF, 2'b11, 4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_cond_err", a.cond_err, 1'b1);
    chk("t5_flags", flags2, 4'b0001);
    chk("t5_regwrite", a.RegWrite, 1'b0);
    chk("t5_memwrite", a.MemWrite, 1'b0);
    drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    chk("drain_valid", a.out_valid, 1'b0);
    chk("drain_hold_cond_err", a.cond_err, 1'b1);
    chk("drain_in_ready", a.in_ready, 1'b1);
    tick;
    chk("idle_skip", skip2, sat2(cnt));
    chk("idle_flags", flags2, 4'b0001);
    sweep(4'b0001, 16'h6A6A);
    sweep(4'b1010, 16'h6996);
    sweep(4'b0100, 16'h66A9);
    sweep(4'b1001, 16'h565A);
    repeat (5) begin
      issue(4'hD, 2'b11, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6_flags", flags2, 4'b1001);
    end
    chk("t6_saturated", skip2, 2'd3);
    chk("t6_shadow_count", skip8, cnt[7:0]);
    a.out_ready = 1'b0;
    drive(1'b1, 4'hE, 2'b11, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) tick;
    chk("t6_stall_valid", a.out_valid, 1'b1);
    chk("t6_stall_in_ready", a.in_ready, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", a.out_valid, 1'b0);
    chk("t6_rst_flags", flags2, 4'b0101);
    chk("t6_rst_skip", skip2, 2'd0);
    chk("t6_rst_skip8", skip8, 8'd0);
    chk("t6_rst_flags8", flags8, 4'b0000);
    chk("t6_rst_condex", a.CondEx, 1'b0);
    drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    a.out_ready = 1'b1;
    tick;
    reset_n = 1'b1;
    tick;
    chk("post_rst_valid", a.out_valid, 1'b0);
    chk("post_rst_flags", flags2, 4'b0101);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
